core_pc_gen: RTL and testbench
==============================

CORE_PC_GEN -- requirements
Module: core_pc_gen

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the PC width (`InstAddressBus).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port jump_flag_in  input  1  redirect request from execute/branch stage.
REQ-006 SHALL have port jump_addr_in  input  ADDR_W  redirect target.
REQ-007 SHALL have port hold_flag_in  input  1  pipeline stall request from downstream.
REQ-008 SHALL have port bus_grant_in  input  1  fetch bus granted to this core as master.
REQ-009 SHALL have port bus_req_out  output  1  request for fetch-bus mastership.
REQ-010 SHALL have port pc_addr_out  output  ADDR_W  current fetch address driven to the fetch stage.
REQ-011 SHALL have port pc_valid_out  output  1  pc_addr_out is a live fetch this cycle.
REQ-012 SHALL have port misalign_out  output  1  one-cycle pulse: jump target not word-aligned.

Function
REQ-013 SHALL implement states IDLE, REQ, FETCH as a registered FSM.
REQ-014 SHALL move IDLE->REQ on the first rising edge after rst deasserts; bus_req_out=1 in REQ and FETCH, 0 in IDLE.
REQ-015 SHALL move REQ->FETCH on an edge with bus_grant_in=1; pc_valid_out=1 only in FETCH (registered, asserted the cycle after grant sampled).
REQ-016 SHALL move FETCH->REQ on an edge with bus_grant_in=0; pc_valid_out drops to 0 next cycle, pc_addr_out unchanged.
REQ-017 SHALL, in FETCH with grant held, update PC each edge by priority: aligned jump > hold > increment.
REQ-018 SHALL on aligned jump (jump_addr_in[1:0]==2'b00) load pc_addr_out=jump_addr_in next cycle, in REQ or FETCH.
REQ-019 SHALL on misaligned jump leave PC unchanged, ignore the redirect, and assert misalign_out for exactly one cycle.
REQ-020 SHALL on hold_flag_in=1 (no jump) keep pc_addr_out unchanged; pc_valid_out stays 1.
REQ-021 SHALL on increment set pc_addr_out=pc_addr_out+4 modulo 2^ADDR_W (32'hFFFF_FFFC -> 32'h0000_0000, no flag).
REQ-022 SHALL never increment in IDLE or REQ; aligned jumps in REQ are applied, holds have no effect.
REQ-023 SHALL give jump priority over hold when both asserted in the same cycle.
REQ-024 SHALL, when grant drops in the same cycle as an aligned jump, apply the jump and go to REQ.
REQ-025 SHALL keep misalign_out 0 in all cycles except the pulse in REQ-019.
REQ-026 SHALL ignore jump_addr_in when jump_flag_in=0.

Reset
REQ-027 SHALL on rst=1 immediately (asynchronously) force state=IDLE, pc_addr_out=RESET_VECTOR, pc_valid_out=0, bus_req_out=0, misalign_out=0.
REQ-028 SHALL, on reset asserted mid-FETCH, abandon the current fetch and any same-cycle jump; no partial update survives.
REQ-029 SHALL hold all outputs at reset values while rst=1 regardless of other inputs.

Verification
REQ-030 SHALL cover: reset release, grant=1 constant -> IDLE, REQ, FETCH; pc_valid_out rises cycle 3; pc_addr_out 0x0, 0x4, 0x8 on successive FETCH cycles.
REQ-031 SHALL cover: in FETCH at pc 0x10, jump_flag_in=1 + hold_flag_in=1, jump_addr_in=0x200 -> next pc 0x200, then 0x204.
REQ-032 SHALL cover: jump_addr_in=0x202 -> pc unchanged, misalign_out=1 one cycle, then increment resumes.
REQ-033 SHALL cover: pc 0xFFFF_FFF8, no hold -> 0xFFFF_FFFC, then 0x0000_0000.
REQ-034 SHALL cover: grant dropped 3 cycles at pc 0x40 -> pc_valid_out=0, pc stays 0x40; grant returns -> valid=1, pc 0x40 then 0x44.
REQ-035 SHALL cover: rst pulsed mid-FETCH between edges -> outputs at reset values before next edge; restart from RESET_VECTOR.

Source files
------------

// File: rtl/core_pc_gen.sv
// Purpose: program-counter generator that owns the fetch-bus request and produces fetch addresses.
// Latency: one cycle; redirects, holds and increments all appear on pc_addr_out after the next clk edge.
// Backpressure: hold_flag_in freezes the PC in FETCH, and a dropped bus_grant_in parks the core in REQ with the PC kept.
module core_pc_gen #(
  parameter int                 ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_flag_in,
  input  logic [ADDR_W-1:0] jump_addr_in,
  input  logic              hold_flag_in,
  input  logic              bus_grant_in,
  output logic              bus_req_out,
  output logic [ADDR_W-1:0] pc_addr_out,
  output logic              pc_valid_out,
  output logic              misalign_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_FETCH = 2'b10
  } state_t;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pc_valid_q, pc_valid_d;
  logic              misalign_q, misalign_d;

  // Jump qualification: only word-aligned targets may redirect the PC.
  logic jump_aligned;
  logic jump_misaligned;

  // Classify the incoming redirect; the target is ignored when no jump is requested.
  always_comb begin
    jump_aligned    = 1'b0;
    jump_misaligned = 1'b0;
    if (jump_flag_in) begin
      if (jump_addr_in[1:0] == 2'b00) begin
        jump_aligned = 1'b1;
      end else begin
        jump_misaligned = 1'b1;
      end
    end
  end

  // Next-state and next-PC selection: aligned jump beats hold, hold beats increment.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // One idle cycle after reset, then ask for the bus.
        state_d = ST_REQ;
      end
      ST_REQ: begin
        // Waiting for the bus: redirects still land, holds and increments do not.
        if (jump_aligned) begin
          pc_d = jump_addr_in;
        end
        misalign_d = jump_misaligned;
        if (bus_grant_in) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (jump_aligned) begin
          pc_d = jump_addr_in;
        end else if (jump_misaligned) begin
          // Bad target: keep the PC where it is and flag it for one cycle.
          misalign_d = 1'b1;
        end else if (hold_flag_in) begin
          pc_d = pc_q;
        end else if (bus_grant_in) begin
          // Wraps silently at the top of the address space.
          pc_d = pc_q + PC_STEP;
        end
        // Losing the grant parks us in REQ; the PC keeps the pending address.
        if (!bus_grant_in) begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Valid is registered and simply mirrors being in FETCH.
    pc_valid_d = (state_d == ST_FETCH);
  end

  // State and datapath registers; reset discards any in-flight fetch or same-cycle jump.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      misalign_q <= misalign_d;
    end
  end

  // Outputs come straight from flops, so reset forces them without waiting for an edge.
  always_comb begin
    bus_req_out  = (state_q != ST_IDLE);
    pc_addr_out  = pc_q;
    pc_valid_out = pc_valid_q;
    misalign_out = misalign_q;
  end

endmodule

// File: tb/tb_core_pc_gen.sv
// Purpose: self-checking bench for core_pc_gen with directed scenarios followed by random traffic.
// Latency: every step applies inputs after an edge and checks outputs 1 time unit after the next edge.
// Backpressure: grant drops and holds are driven both directed and at random against a spec-level model.
module tb_core_pc_gen;

  logic        clk;
  logic        rst;
  logic        jump_flag_in;
  logic [31:0] jump_addr_in;
  logic        hold_flag_in;
  logic        bus_grant_in;
  logic        bus_req_out;
  logic [31:0] pc_addr_out;
  logic        pc_valid_out;
  logic        misalign_out;

  int checks   = 0;
  int failures = 0;

  // Reference model: "has the core asked for the bus", "is it fetching", and the PC.
  bit          m_requesting;
  bit          m_fetching;
  logic [31:0] m_pc;
  bit          m_misalign;

  core_pc_gen #(
    .ADDR_W      (32),
    .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .jump_flag_in(jump_flag_in),
    .jump_addr_in(jump_addr_in),
    .hold_flag_in(hold_flag_in),
    .bus_grant_in(bus_grant_in),
    .bus_req_out (bus_req_out),
    .pc_addr_out (pc_addr_out),
    .pc_valid_out(pc_valid_out),
    .misalign_out(misalign_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},       pc_addr_out,          m_pc);
    chk({tag, ".valid"},    32'(pc_valid_out),    32'(m_fetching));
    chk({tag, ".bus_req"},  32'(bus_req_out),     32'(m_requesting));
    chk({tag, ".misalign"}, 32'(misalign_out),    32'(m_misalign));
  endtask

  task automatic model_reset();
    m_requesting = 1'b0;
    m_fetching   = 1'b0;
    m_pc         = 32'h0000_0000;
    m_misalign   = 1'b0;
  endtask

  // One clock edge of the specified behaviour, written from the rules rather than a state machine.
  task automatic model_edge(input bit jf, input logic [31:0] ja, input bit hf, input bit gr);
    bit good_jump;
    bit bad_jump;
    good_jump  = jf && (ja % 4 == 0);
    bad_jump   = jf && (ja % 4 != 0);
    m_misalign = 1'b0;
    if (!m_requesting) begin
      m_requesting = 1'b1;
    end else begin
      if (good_jump) m_pc = ja;
      else if (bad_jump) m_misalign = 1'b1;
      else if (m_fetching && !hf && gr) m_pc = m_pc + 32'd4;
      m_fetching = gr;
    end
  endtask

  task automatic step(input bit r, input bit jf, input logic [31:0] ja,
                      input bit hf, input bit gr, input string tag);
    rst          = r;
    jump_flag_in = jf;
    jump_addr_in = ja;
    hold_flag_in = hf;
    bus_grant_in = gr;
    @(posedge clk);
    if (r) model_reset();
    else   model_edge(jf, ja, hf, gr);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] rnd;
    bit          r, jf, hf, gr;

    rst          = 1'b1;
    jump_flag_in = 1'b0;
    jump_addr_in = 32'h0;
    hold_flag_in = 1'b0;
    bus_grant_in = 1'b1;
    model_reset();
    #2;
    check_all("reset_t0");
    step(1, 1, 32'h0000_0080, 1, 1, "reset_hold0");
    step(1, 0, 32'h0,         0, 1, "reset_hold1");

    // Power-up with grant tied high: IDLE, REQ, then fetches at 0, 4, 8.
    step(0, 0, 32'h0, 0, 1, "boot_req");
    step(0, 0, 32'h0, 0, 1, "boot_fetch0");
    step(0, 0, 32'h0, 0, 1, "boot_fetch4");
    step(0, 0, 32'h0, 0, 1, "boot_fetch8");
    step(0, 0, 32'h0, 0, 1, "run_c");
    step(0, 0, 32'h0, 0, 1, "run_10");

    // Jump beats hold.
    step(0, 1, 32'h0000_0200, 1, 1, "jump_over_hold");
    step(0, 0, 32'h0,         0, 1, "after_jump");

    // Misaligned target is ignored and flagged for one cycle.
    step(0, 1, 32'h0000_0202, 0, 1, "misalign_pulse");
    step(0, 0, 32'h0,         0, 1, "misalign_clear");

    // Hold keeps the PC and the fetch valid.
    step(0, 0, 32'h0, 1, 1, "hold0");
    step(0, 0, 32'h0, 1, 1, "hold1");

    // Wrap at the top of the address space.
    step(0, 1, 32'hFFFF_FFF8, 0, 1, "wrap_load");
    step(0, 0, 32'h0,         0, 1, "wrap_fffc");
    step(0, 0, 32'h0,         0, 1, "wrap_zero");

    // Grant withdrawn for three cycles at 0x40.
    step(0, 1, 32'h0000_0040, 0, 1, "grant_load40");
    step(0, 0, 32'h0, 0, 0, "grant_off0");
    step(0, 0, 32'h0, 0, 0, "grant_off1");
    step(0, 0, 32'h0, 0, 0, "grant_off2");
    step(0, 0, 32'h0, 0, 1, "grant_back40");
    step(0, 0, 32'h0, 0, 1, "grant_back44");

    // Jump coinciding with grant loss, then REQ-state jumps and holds.
    step(0, 1, 32'h0000_0100, 0, 0, "jump_grant_drop");
    step(0, 0, 32'h0,         1, 0, "req_hold");
    step(0, 1, 32'h0000_0300, 0, 0, "req_jump");
    step(0, 1, 32'h0000_0301, 0, 1, "req_misalign");
    step(0, 0, 32'h0,         0, 1, "req_resume");
    step(0, 0, 32'h0,         0, 1, "req_resume2");

    // Reset between edges mid-fetch with a jump pending.
    rst          = 1'b1;
    jump_flag_in = 1'b1;
    jump_addr_in = 32'h0000_0500;
    model_reset();
    #1;
    check_all("rst_async");
    step(1, 1, 32'h0000_0500, 0, 1, "rst_edge");
    step(0, 0, 32'h0, 0, 1, "restart_req");
    step(0, 0, 32'h0, 0, 1, "restart_fetch0");
    step(0, 0, 32'h0, 0, 1, "restart_fetch4");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rnd = $urandom();
      r   = ($urandom_range(99) < 2);
      jf  = ($urandom_range(99) < 20);
      hf  = ($urandom_range(99) < 30);
      gr  = ($urandom_range(99) < 80);
      if ($urandom_range(99) < 70) rnd = rnd & 32'hFFFF_FFFC;
      step(r, jf, rnd, hf, gr, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
